// File: rtl/pulpino_boot_seq.sv
// Power-up / reset sequencer for the PULPino core.
// Qualifies PLL lock, debounces KEY[0], honours JTAG reset requests and
// releases core reset followed by fetch_enable in a fixed order.
module pulpino_boot_seq #(
  parameter int unsigned DEBOUNCE_CYCLES    = 250000,
  parameter int unsigned RESET_HOLD_CYCLES  = 64,
  parameter int unsigned FETCH_DELAY_CYCLES = 16,
  parameter logic [31:0] BOOT_ADDR          = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pll_locked_i,
  input  logic        key_reset_n_i,
  input  logic        jtag_reset_i,
  output logic        core_reset_n_o,
  output logic        fetch_enable_o,
  output logic [31:0] boot_addr_o,
  output logic [2:0]  state_o,
  output logic [7:0]  boot_count_o
);

  localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned MAX_DLY = (RESET_HOLD_CYCLES > FETCH_DELAY_CYCLES) ?
                                    RESET_HOLD_CYCLES : FETCH_DELAY_CYCLES;
  localparam int unsigned DLY_W   = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    HOLD      = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    JTAG_HOLD = 3'd4
  } state_e;

  if (RESET_HOLD_CYCLES == 0 || FETCH_DELAY_CYCLES == 0) begin : g_param_chk
    $error("pulpino_boot_seq: RESET_HOLD_CYCLES and FETCH_DELAY_CYCLES must be >= 1");
  end

  logic              lock_s1_q, lock_sync_q;
  logic              key_s1_q, key_sync_q;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              key_db_q, key_db_d;
  state_e            state_q, state_d;
  logic [DLY_W-1:0]  dly_cnt_q, dly_cnt_d;
  logic [7:0]        boot_cnt_q, boot_cnt_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              fetch_en_q, fetch_en_d;

  // Two-flop synchronisers for the asynchronous board inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_s1_q   <= 1'b0;
      lock_sync_q <= 1'b0;
      key_s1_q    <= 1'b1;
      key_sync_q  <= 1'b1;
    end else begin
      lock_s1_q   <= pll_locked_i;
      lock_sync_q <= lock_s1_q;
      key_s1_q    <= key_reset_n_i;
      key_sync_q  <= key_s1_q;
    end
  end

  // Debounce: accept a new key level after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    db_cnt_d = db_cnt_q;
    key_db_d = key_db_q;
    if (key_sync_q == key_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      key_db_d = key_sync_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Next-state logic; rule order gives lock/key loss priority over JTAG.
  always_comb begin
    state_d = WAIT_LOCK;
    if (!lock_sync_q || !key_db_q) begin
      state_d = WAIT_LOCK;
    end else if (jtag_reset_i &&
                 (state_q == HOLD || state_q == RELEASE || state_q == RUN)) begin
      state_d = JTAG_HOLD;
    end else begin
      case (state_q)
        WAIT_LOCK: state_d = jtag_reset_i ? WAIT_LOCK : HOLD;
        HOLD:      state_d = (dly_cnt_q == DLY_W'(RESET_HOLD_CYCLES - 1)) ? RELEASE : HOLD;
        RELEASE:   state_d = (dly_cnt_q == DLY_W'(FETCH_DELAY_CYCLES - 1)) ? RUN : RELEASE;
        RUN:       state_d = RUN;
        JTAG_HOLD: state_d = jtag_reset_i ? JTAG_HOLD : HOLD;
        default:   state_d = WAIT_LOCK;
      endcase
    end
  end

  // Delay counter, boot counter and output decode from the next state.
  always_comb begin
    dly_cnt_d = '0;
    if (state_d == state_q && (state_q == HOLD || state_q == RELEASE)) begin
      dly_cnt_d = dly_cnt_q + 1'b1;
    end
    boot_cnt_d = boot_cnt_q;
    if (state_q == RELEASE && state_d == RUN && boot_cnt_q != 8'hFF) begin
      boot_cnt_d = boot_cnt_q + 8'd1;
    end
    core_rst_n_d = (state_d == RELEASE) || (state_d == RUN);
    fetch_en_d   = (state_d == RUN);
  end

  // Debounce, FSM and registered output state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_q     <= '0;
      key_db_q     <= 1'b1;
      state_q      <= WAIT_LOCK;
      dly_cnt_q    <= '0;
      boot_cnt_q   <= '0;
      core_rst_n_q <= 1'b0;
      fetch_en_q   <= 1'b0;
    end else begin
      db_cnt_q     <= db_cnt_d;
      key_db_q     <= key_db_d;
      state_q      <= state_d;
      dly_cnt_q    <= dly_cnt_d;
      boot_cnt_q   <= boot_cnt_d;
      core_rst_n_q <= core_rst_n_d;
      fetch_en_q   <= fetch_en_d;
    end
  end

  assign core_reset_n_o = core_rst_n_q;
  assign fetch_enable_o = fetch_en_q;
  assign boot_addr_o    = BOOT_ADDR;
  assign state_o        = state_q;
  assign boot_count_o   = boot_cnt_q;

endmodule
